// File: rtl/sap_controller.sv
// SAP-U controller-sequencer: a one-hot T1..T6 ring counter and an opcode decoder that
// together drive the 12-bit datapath control word, including the HLT freeze.
module sap_controller #(
    parameter logic [3:0] LDA_OP = 4'b0000,
    parameter logic [3:0] ADD_OP = 4'b0001,
    parameter logic [3:0] SUB_OP = 4'b0010,
    parameter logic [3:0] OUT_OP = 4'b1110,
    parameter logic [3:0] HLT_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  tstate,
    output logic        halt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    // Bit order: CP EP LM_n CE_n LI_n EI_n LA_n EA SU EU LB_n LO_n
    localparam logic [11:0] CON_NOP     = 12'h3E3;
    localparam logic [11:0] CON_FETCH1  = 12'h5E3;
    localparam logic [11:0] CON_FETCH2  = 12'hBE3;
    localparam logic [11:0] CON_FETCH3  = 12'h263;
    localparam logic [11:0] CON_MAR_IR  = 12'h1A3;
    localparam logic [11:0] CON_RAM_A   = 12'h2C3;
    localparam logic [11:0] CON_RAM_B   = 12'h2E1;
    localparam logic [11:0] CON_ADD_A   = 12'h3C7;
    localparam logic [11:0] CON_SUB_A   = 12'h3CF;
    localparam logic [11:0] CON_A_OUT   = 12'h3F2;

    tstate_t     state_r;
    tstate_t     state_next_s;
    logic        halted_r;
    logic        halted_next_s;
    logic [11:0] con_s;

    // State and halted-flag registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= T1;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            halted_r <= halted_next_s;
        end
    end

    // Ring advance; HLT parks the ring at T4 and latches the halted flag.
    always_comb begin
        state_next_s  = T1;
        halted_next_s = halted_r;
        if (halted_r) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                T1:      state_next_s = T2;
                T2:      state_next_s = T3;
                T3:      state_next_s = T4;
                T4: begin
                    if (opcode == HLT_OP) begin
                        state_next_s  = T4;
                        halted_next_s = 1'b1;
                    end else begin
                        state_next_s = T5;
                    end
                end
                T5:      state_next_s = T6;
                T6:      state_next_s = T1;
                default: state_next_s = T1;
            endcase
        end
    end

    // Control word decode; every path not listed leaves the bus idle.
    always_comb begin
        con_s = CON_NOP;
        if (clr || halted_r) begin
            con_s = CON_NOP;
        end else begin
            case (state_r)
                T1: con_s = CON_FETCH1;
                T2: con_s = CON_FETCH2;
                T3: con_s = CON_FETCH3;
                T4: begin
                    case (opcode)
                        LDA_OP, ADD_OP, SUB_OP: con_s = CON_MAR_IR;
                        OUT_OP:                 con_s = CON_A_OUT;
                        default:                con_s = CON_NOP;
                    endcase
                end
                T5: begin
                    case (opcode)
                        LDA_OP:         con_s = CON_RAM_A;
                        ADD_OP, SUB_OP: con_s = CON_RAM_B;
                        default:        con_s = CON_NOP;
                    endcase
                end
                T6: begin
                    case (opcode)
                        ADD_OP:  con_s = CON_ADD_A;
                        SUB_OP:  con_s = CON_SUB_A;
                        default: con_s = CON_NOP;
                    endcase
                end
                default: con_s = CON_NOP;
            endcase
        end
    end

    assign con    = con_s;
    assign tstate = state_r;
    assign halt   = halted_r & ~clr;

endmodule
